// File: rtl/nios2_subsystem_pio_data_in_pkg.sv
// Shared constants for the PIO capture FIFO: register map, STATUS/CONTROL
// bit layout and default sizing.
package nios2_subsystem_pio_data_in_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int DEPTH_DEFAULT  = 8;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_STATUS  = 2'd1,
    REG_CONTROL = 2'd2,
    REG_RSVD    = 2'd3
  } reg_addr_e;

  localparam int STATUS_LEVEL_LSB = 0;
  localparam int STATUS_LEVEL_W   = 8;
  localparam int STATUS_EMPTY_BIT = 8;
  localparam int STATUS_FULL_BIT  = 9;
  localparam int STATUS_OVF_BIT   = 10;
  localparam int STATUS_UDF_BIT   = 11;

  localparam int CTRL_THRESH_LSB  = 0;
  localparam int CTRL_THRESH_W    = 8;
  localparam int CTRL_IRQ_EN_BIT  = 8;
  localparam int CTRL_FLUSH_BIT   = 9;

  // Level must represent 0..DEPTH inclusive, hence DEPTH+1 codes.
  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [31:0] pack_status(
    input logic [STATUS_LEVEL_W-1:0] level,
    input logic                      empty,
    input logic                      full,
    input logic                      ovf,
    input logic                      udf
  );
    logic [31:0] word;
    word                                           = '0;
    word[STATUS_LEVEL_LSB +: STATUS_LEVEL_W]       = level;
    word[STATUS_EMPTY_BIT]                         = empty;
    word[STATUS_FULL_BIT]                          = full;
    word[STATUS_OVF_BIT]                           = ovf;
    word[STATUS_UDF_BIT]                           = udf;
    return word;
  endfunction

  function automatic logic [31:0] pack_control(
    input logic [CTRL_THRESH_W-1:0] threshold,
    input logic                     irq_en
  );
    logic [31:0] word;
    word                                     = '0;
    word[CTRL_THRESH_LSB +: CTRL_THRESH_W]   = threshold;
    word[CTRL_IRQ_EN_BIT]                    = irq_en;
    return word;
  endfunction

endpackage

// File: rtl/nios2_subsystem_sync_fifo.sv
// Single-clock FIFO with combinational head, flush and next-level output so
// the owner can derive flags from post-update occupancy.
module nios2_subsystem_sync_fifo
  import nios2_subsystem_pio_data_in_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT,
  parameter int LVL_W  = level_width(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] head,
  output logic [LVL_W-1:0]  level,
  output logic [LVL_W-1:0]  level_nxt,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Flush takes priority: any push or pop in the same cycle is dropped.
  assign push_ok = push && !full  && !flush;
  assign pop_ok  = pop  && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LVL_W'(1);
        2'b01:   level_d = level_q - LVL_W'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is left out of reset; stale entries are unreachable once the
  // pointers and level are cleared.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  assign head      = mem[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;

endmodule

// File: rtl/nios2_subsystem_pio_data_in.sv
// Avalon-MM PIO input port: buffers fabric samples in a FIFO, exposes
// DATA/STATUS/CONTROL registers with sticky error flags and a threshold irq.
module nios2_subsystem_pio_data_in
  import nios2_subsystem_pio_data_in_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              irq
);

  localparam int LVL_W = level_width(DEPTH);

  logic [DATA_W-1:0] fifo_head;
  logic [LVL_W-1:0]  fifo_level;
  logic [LVL_W-1:0]  fifo_level_nxt;
  logic              fifo_full;
  logic              fifo_empty;

  logic              rd_data;
  logic              wr_status;
  logic              wr_ctrl;
  logic              flush;

  logic                     ovf_q, ovf_d;
  logic                     udf_q, udf_d;
  logic [CTRL_THRESH_W-1:0] threshold_q, threshold_d;
  logic                     irq_en_q, irq_en_d;
  logic                     irq_q, irq_d;

  logic [31:0]              head_ext;
  logic [STATUS_LEVEL_W-1:0] level_ext;
  logic                     unused_wdata;

  assign rd_data   = chipselect && !read_n  && (address == REG_DATA);
  assign wr_status = chipselect && !write_n && (address == REG_STATUS);
  assign wr_ctrl   = chipselect && !write_n && (address == REG_CONTROL);
  assign flush     = wr_ctrl && writedata[CTRL_FLUSH_BIT];

  assign unused_wdata = ^writedata[31:12];

  nios2_subsystem_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (rd_data),
    .flush     (flush),
    .head      (fifo_head),
    .level     (fifo_level),
    .level_nxt (fifo_level_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign in_ready = !fifo_full;

  always_comb begin
    ovf_d       = ovf_q;
    udf_d       = udf_q;
    threshold_d = threshold_q;
    irq_en_d    = irq_en_q;

    if (wr_status && writedata[STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (wr_status && writedata[STATUS_UDF_BIT]) udf_d = 1'b0;
    // A new error in the same cycle as a clear must survive the clear.
    if (in_valid && fifo_full && !flush) ovf_d = 1'b1;
    if (rd_data && fifo_empty && !flush) udf_d = 1'b1;

    if (wr_ctrl) begin
      threshold_d = writedata[CTRL_THRESH_LSB +: CTRL_THRESH_W];
      irq_en_d    = writedata[CTRL_IRQ_EN_BIT];
    end

    irq_d = irq_en_d &&
            (((threshold_d != '0) && (CTRL_THRESH_W'(fifo_level_nxt) >= threshold_d)) ||
             ovf_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
      threshold_q <= '0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
      threshold_q <= threshold_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
    end
  end

  assign irq = irq_q;

  always_comb begin
    head_ext                = '0;
    head_ext[DATA_W-1:0]    = fifo_head;
    level_ext               = STATUS_LEVEL_W'(fifo_level);
  end

  // Zero-latency read path; DATA shows the head before this cycle's pop.
  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:    readdata = fifo_empty ? 32'd0 : head_ext;
      REG_STATUS:  readdata = pack_status(level_ext, fifo_empty, fifo_full, ovf_q, udf_q);
      REG_CONTROL: readdata = pack_control(threshold_q, irq_en_q);
      default:     readdata = '0;
    endcase
  end

endmodule
